// File: rtl/muldiv_seq.sv
// HI/LO sequencer: accepts one mult/div/move request, drives the arithmetic
// units, and commits the result to HI/LO in a single write-back cycle.
module muldiv_seq #(
    parameter int unsigned MUL_LAT     = 1,
    parameter int unsigned DIV_TIMEOUT = 40
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        op_valid_i,
    output logic        op_ready_o,
    input  logic [2:0]  op_code_i,
    input  logic [31:0] rs_data_i,
    input  logic [31:0] rt_data_i,
    input  logic        abort_i,
    output logic [31:0] src_a_o,
    output logic [31:0] src_b_o,
    output logic        div_start_o,
    output logic        divu_start_o,
    input  logic        div_busy_i,
    input  logic        divu_busy_i,
    input  logic [31:0] div_q_i,
    input  logic [31:0] div_r_i,
    input  logic [31:0] divu_q_i,
    input  logic [31:0] divu_r_i,
    input  logic [63:0] mul_prod_i,
    input  logic [63:0] multu_prod_i,
    output logic        hi_ena_o,
    output logic        lo_ena_o,
    output logic [31:0] hi_wdata_o,
    output logic [31:0] lo_wdata_o,
    output logic        done_o,
    output logic        err_o,
    output logic        stall_o
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_MUL       = 3'd1;
    localparam logic [2:0] ST_DIV_START = 3'd2;
    localparam logic [2:0] ST_DIV_WAIT  = 3'd3;
    localparam logic [2:0] ST_WB        = 3'd4;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    logic [2:0]  state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] src_a_q, src_a_d;
    logic [31:0] src_b_q, src_b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        err_q, err_d;
    logic [31:0] cnt_q, cnt_d;
    logic        seen_busy_q, seen_busy_d;

    // Bit 0 of the op code distinguishes the unsigned unit in both mult and div pairs.
    logic        sel_busy;
    logic [31:0] sel_q;
    logic [31:0] sel_r;
    logic [63:0] sel_prod;

    // Select the arithmetic unit that belongs to the latched op.
    always_comb begin
        sel_busy = op_q[0] ? divu_busy_i  : div_busy_i;
        sel_q    = op_q[0] ? divu_q_i     : div_q_i;
        sel_r    = op_q[0] ? divu_r_i     : div_r_i;
        sel_prod = op_q[0] ? multu_prod_i : mul_prod_i;
    end

    // Next-state and result capture.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        src_a_d     = src_a_q;
        src_b_d     = src_b_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        seen_busy_d = seen_busy_q;
        case (state_q)
            ST_IDLE: begin
                // An abort in IDLE blocks acceptance for that cycle.
                if (op_valid_i && !abort_i) begin
                    op_d    = op_code_i;
                    src_a_d = rs_data_i;
                    src_b_d = rt_data_i;
                    cnt_d   = 32'd0;
                    err_d   = 1'b0;
                    hi_d    = 32'd0;
                    lo_d    = 32'd0;
                    case (op_code_i)
                        OP_MULT, OP_MULTU: state_d = ST_MUL;
                        OP_DIV, OP_DIVU: begin
                            if (rt_data_i == 32'd0) begin
                                err_d   = 1'b1;
                                state_d = ST_WB;
                            end else begin
                                state_d = ST_DIV_START;
                            end
                        end
                        OP_MTHI, OP_MTLO: begin
                            hi_d    = rs_data_i;
                            lo_d    = rs_data_i;
                            state_d = ST_WB;
                        end
                        default: begin
                            err_d   = 1'b1;
                            state_d = ST_WB;
                        end
                    endcase
                end
            end
            ST_MUL: begin
                if (cnt_q == MUL_LAT - 1) begin
                    hi_d    = sel_prod[63:32];
                    lo_d    = sel_prod[31:0];
                    state_d = ST_WB;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_DIV_START: begin
                cnt_d       = 32'd0;
                seen_busy_d = 1'b0;
                state_d     = ST_DIV_WAIT;
            end
            ST_DIV_WAIT: begin
                if (sel_busy) begin
                    seen_busy_d = 1'b1;
                end
                // Completion wins over a timeout landing on the same cycle.
                if (seen_busy_q && !sel_busy) begin
                    hi_d    = sel_r;
                    lo_d    = sel_q;
                    state_d = ST_WB;
                end else if (cnt_q == DIV_TIMEOUT - 1) begin
                    err_d   = 1'b1;
                    state_d = ST_WB;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (abort_i && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            op_q        <= 3'd0;
            src_a_q     <= 32'd0;
            src_b_q     <= 32'd0;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
            err_q       <= 1'b0;
            cnt_q       <= 32'd0;
            seen_busy_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            src_a_q     <= src_a_d;
            src_b_q     <= src_b_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            seen_busy_q <= seen_busy_d;
        end
    end

    // Output decode; abort during WB suppresses completion and writes.
    always_comb begin
        logic wb_live;
        wb_live      = (state_q == ST_WB) && !abort_i;
        op_ready_o   = (state_q == ST_IDLE);
        stall_o      = (state_q != ST_IDLE);
        src_a_o      = src_a_q;
        src_b_o      = src_b_q;
        div_start_o  = (state_q == ST_DIV_START) && (op_q == OP_DIV);
        divu_start_o = (state_q == ST_DIV_START) && (op_q == OP_DIVU);
        done_o       = wb_live;
        err_o        = wb_live && err_q;
        hi_ena_o     = wb_live && !err_q && (op_q != OP_MTLO);
        lo_ena_o     = wb_live && !err_q && (op_q != OP_MTHI);
        hi_wdata_o   = hi_ena_o ? hi_q : 32'd0;
        lo_wdata_o   = lo_ena_o ? lo_q : 32'd0;
    end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
Sequencer for the HI/LO arithmetic resources of the multi-cycle CPU.
- Accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO request at a time from the control unit.
- Drives latched operands and start pulses to the mult/multu/div/divu units, waits for completion, then writes HI/LO in a single write-back cycle.
- Stalls the control unit until done.
- Replaces the control unit's ad-hoc busy polling.

Parameters:
MUL_LAT, 1, cycles spent in MUL state before result capture (>=1)
DIV_TIMEOUT, 40, max cycles in DIV_WAIT before error abort (>=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
op_valid  in  1  request present
op_ready  out  1  sequencer can accept (state==IDLE)
op_code  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x illegal
rs_data  in  32  operand A
rt_data  in  32  operand B
abort  in  1  cancel current operation (exception/eret)
src_a  out  32  latched operand A to mult/multu/div/divu
src_b  out  32  latched operand B
div_start  out  1  one-cycle start to div
divu_start  out  1  one-cycle start to divu
div_busy  in  1  div busy
divu_busy  in  1  divu busy
div_q, div_r  in  32 each  div quotient/remainder
divu_q, divu_r  in  32 each  divu quotient/remainder
mul_prod  in  64  signed product of src_a*src_b
multu_prod  in  64  unsigned product
hi_ena, lo_ena  out  1 each  HI/LO write enables
hi_wdata, lo_wdata  out  32 each  HI/LO write data
done  out  1  one-cycle completion pulse
err  out  1  valid with done: div-by-zero, timeout or illegal op
stall  out  1  state!=IDLE

Behaviour:
- Reset (rst=1 at a clock edge, any state): state=IDLE; src_a, src_b, result regs, op reg, counters=0. All outputs 0 except op_ready=1. rst dominates abort and op_valid.
- States: IDLE, MUL, DIV_START, DIV_WAIT, WB.
- IDLE: op_ready=1. When op_valid=1, latch op_code/rs_data/rt_data into op/src_a/src_b, then:
  - MULT/MULTU -> MUL.
  - DIV/DIVU with rt_data!=0 -> DIV_START.
  - DIV/DIVU with rt_data==0 -> WB with err=1, no writes.
  - MTHI/MTLO -> WB, result = rs_data.
  - illegal -> WB with err=1, no writes.
- MUL: counter runs MUL_LAT cycles. On the last cycle, capture {hi,lo} = prod[63:32], prod[31:0] (mul_prod or multu_prod per op). Then go to WB.
- DIV_START: assert div_start (DIV) or divu_start (DIVU) for exactly this cycle. Clear seen_busy and timer. Go to DIV_WAIT.
- DIV_WAIT:
  - Set seen_busy when the selected busy=1.
  - When seen_busy=1 and busy=0: capture hi=r, lo=q and go to WB.
  - Timer increments each cycle. When timer reaches DIV_TIMEOUT-1 without completion: go to WB with err=1, no writes.
  - Busy never rising is covered by the timeout.
- WB (one cycle): done=1, err per flag.
  - hi_ena=1 for MULT/MULTU/DIV/DIVU/MTHI; lo_ena=1 for MULT/MULTU/DIV/DIVU/MTLO.
  - hi_ena=lo_ena=0 whenever err=1.
  - hi_wdata/lo_wdata driven from result regs (0 when enable low).
  - Next state IDLE.
- Latency, accept at cycle T:
  - MTHI/MTLO: WB at T+1.
  - MULT: WB at T+MUL_LAT+1.
  - DIV: start at T+1, WB one cycle after first busy-low observed following busy-high.
  - op_ready returns 1 the cycle after WB. Back-to-back requests have at least one cycle between done and the next accept.
- src_a/src_b stay stable from accept until return to IDLE; they are not cleared on done.
- abort=1 in any non-IDLE state, including WB: next state IDLE, no write, no done. If abort coincides with WB, enables in that cycle are forced 0. abort in IDLE is ignored, and the request is not accepted that cycle.
- op_valid while not op_ready: ignored; the requester holds it.
- No internal arithmetic: widths pass through unchanged.

Test Plan:
- Reset, then MTHI rs=0x12345678 -> cycle T+1: hi_ena=1, hi_wdata=0x12345678, lo_ena=0, done=1, err=0; op_ready=1 at T+2.
- MULT rs=0xFFFFFFFE (-2), rt=3, MUL_LAT=1, mul_prod=0xFFFFFFFF_FFFFFFFA -> WB at T+2: hi=0xFFFFFFFF, lo=0xFFFFFFFA, both enables 1.
- DIVU rs=100, rt=7; bench divu holds busy 33 cycles after start -> divu_start pulse exactly at T+1; WB after busy falls with lo=14, hi=2; stall=1 throughout.
- DIV rt=0 -> WB at T+1: err=1, hi_ena=lo_ena=0, div_start never asserted.
- DIV with busy stuck 0, DIV_TIMEOUT=40 -> done with err=1 exactly 40 cycles after entering DIV_WAIT, no writes.
- abort asserted mid DIV_WAIT, then rst asserted mid MUL -> IDLE next cycle, no done/hi_ena/lo_ena; after rst all outputs 0, op_ready=1.
